// File: rtl/wisc_pkg.sv
// Shared constants and types for the shifter issue path: opcodes, shift modes
// and the registered issue entry presented to the Shifter.
package wisc_pkg;

  localparam int unsigned SHIFT_DATA_W = 16;

  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_SLL  = 2'd1,
    MODE_SRA  = 2'd2,
    MODE_ROR  = 2'd3
  } shift_mode_e;

  typedef struct packed {
    logic [SHIFT_DATA_W-1:0] shift_in;
    logic [3:0]              shift_val;
    shift_mode_e             mode;
    logic [3:0]              rd;
  } issue_entry_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of an instruction word into Shifter controls.
// Non-shift opcodes become a pass-through (MODE_NONE, shift_val 0).
module shift_decode
  import wisc_pkg::*;
(
  input  logic [15:0]  instr,
  output shift_mode_e  mode,
  output logic [3:0]   shift_val,
  output logic [3:0]   rd
);

  // The rs field is resolved by the decode stage into in_rs_data.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[7:4];

  always_comb begin
    mode      = MODE_NONE;
    shift_val = 4'd0;
    case (instr[15:12])
      OP_SLL: begin
        mode      = MODE_SLL;
        shift_val = instr[3:0];
      end
      OP_SRA: begin
        mode      = MODE_SRA;
        shift_val = instr[3:0];
      end
      OP_ROR: begin
        mode      = MODE_ROR;
        shift_val = instr[3:0];
      end
      default: ;
    endcase
  end

  assign rd = instr[11:8];

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the 16-bit Shifter, with a 2-entry skid buffer
// and flush. Optional saturating perf counters under SHIFT_PERF_CNT_EN.
module shift_issue_stage
  import wisc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_shift_in,
  output logic [3:0]        out_shift_val,
  output logic [1:0]        out_mode,
  output logic [3:0]        out_rd
`ifdef SHIFT_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_shift_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  // Handshake: a beat moves when valid && ready on the same rising edge.
  // Producers hold valid and payload until accepted; in_ready depends only on
  // registered state (low exactly while the skid entry is occupied).

  issue_entry_t in_entry;
  issue_entry_t out_q;
  issue_entry_t skid_q;
  logic         out_valid_q;
  logic         skid_valid_q;
  shift_mode_e  dec_mode;
  logic [3:0]   dec_shift_val;
  logic [3:0]   dec_rd;
  logic         accept;
  logic         out_load;

  shift_decode u_decode (
    .instr     (in_instr),
    .mode      (dec_mode),
    .shift_val (dec_shift_val),
    .rd        (dec_rd)
  );

  assign in_entry.shift_in  = in_rs_data;
  assign in_entry.shift_val = dec_shift_val;
  assign in_entry.mode      = dec_mode;
  assign in_entry.rd        = dec_rd;

  assign accept   = in_valid && in_ready;
  // Output register may take a new entry when empty or draining this cycle.
  assign out_load = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so nothing is accepted here.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= in_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = out_valid_q;
  assign out_shift_in  = out_q.shift_in;
  assign out_shift_val = out_q.shift_val;
  assign out_mode      = out_q.mode;
  assign out_rd        = out_q.rd;

`ifdef SHIFT_PERF_CNT_EN
  // Counters survive flush; a transfer coinciding with flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_shift_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (out_valid_q && out_ready && (out_q.mode != MODE_NONE) && (perf_shift_cnt != '1))
        perf_shift_cnt <= perf_shift_cnt + CNT_W'(1);
      if (out_valid_q && !out_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: a 2-deep FIFO reference model checked
// every cycle plus hand-computed literal expectations.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_shift_in;
  logic [3:0]  out_shift_val;
  logic [1:0]  out_mode;
  logic [3:0]  out_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference contents of the stage, oldest first: {shift_in, shift_val, mode, rd}.
  logic [25:0] exp_q[$];

`ifdef SHIFT_PERF_CNT_EN
  logic [15:0] perf_shift_cnt, perf_stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_shift_in;
  logic [3:0]  s_shift_val, s_rd;
  logic [1:0]  s_mode;
  logic [1:0]  s_perf_shift, s_perf_stall;
`endif

  always #5 clk = ~clk;

  shift_issue_stage u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_rs_data    (in_rs_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_shift_in  (out_shift_in),
    .out_shift_val (out_shift_val),
    .out_mode      (out_mode),
    .out_rd        (out_rd)
`ifdef SHIFT_PERF_CNT_EN
    ,
    .perf_shift_cnt(perf_shift_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

`ifdef SHIFT_PERF_CNT_EN
  // Narrow-counter copy so saturation is reachable in a few cycles.
  shift_issue_stage #(.CNT_W(2)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .in_instr      (in_instr),
    .in_rs_data    (in_rs_data),
    .out_valid     (s_out_valid),
    .out_ready     (out_ready),
    .out_shift_in  (s_shift_in),
    .out_shift_val (s_shift_val),
    .out_mode      (s_mode),
    .out_rd        (s_rd),
    .perf_shift_cnt(s_perf_shift),
    .perf_stall_cnt(s_perf_stall)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] expect_of(input logic [15:0] instr, input logic [15:0] rs);
    logic [1:0] md;
    logic [3:0] sv;
    case (instr[15:12])
      4'h4:    md = 2'd1;
      4'h5:    md = 2'd2;
      4'h6:    md = 2'd3;
      default: md = 2'd0;
    endcase
    sv = (md != 2'd0) ? instr[3:0] : 4'd0;
    return {rs, sv, md, instr[11:8]};
  endfunction

  // Reference model: a FIFO of capacity 2 that is ready while not full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      automatic bit do_pop  = (exp_q.size() > 0) && out_ready;
      automatic bit do_push = in_valid && (exp_q.size() < 2);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(expect_of(in_instr, in_rs_data));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      chk("cyc_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0)
        chk("cyc_out_entry", 32'({out_shift_in, out_shift_val, out_mode, out_rd}), 32'(exp_q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] ins, input logic [15:0] rs);
    in_valid   = v;
    in_instr   = ins;
    in_rs_data = rs;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    put(1'b0, 16'h0, 16'h0);
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fields", 32'({out_shift_in, out_shift_val, out_mode, out_rd}), 32'd0);
    rst_n = 1'b1;
    step();

    // Single SLL issue, one-cycle latency
    put(1'b1, 16'h4123, 16'h00F0);
    step();
    put(1'b0, 16'h0, 16'h0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_mode", 32'(out_mode), 32'd1);
    chk("t1_sval", 32'(out_shift_val), 32'd3);
    chk("t1_rd", 32'(out_rd), 32'd1);
    chk("t1_shin", 32'(out_shift_in), 32'h00F0);

    // Non-shift pass-through then SRA back to back
    put(1'b1, 16'h0215, 16'h1234);
    step();
    chk("t2_add_mode", 32'(out_mode), 32'd0);
    chk("t2_add_sval", 32'(out_shift_val), 32'd0);
    chk("t2_add_rd", 32'(out_rd), 32'd2);
    chk("t2_add_shin", 32'(out_shift_in), 32'h1234);
    put(1'b1, 16'h5A3F, 16'h8000);
    step();
    put(1'b0, 16'h0, 16'h0);
    chk("t2_sra_mode", 32'(out_mode), 32'd2);
    chk("t2_sra_sval", 32'(out_shift_val), 32'd15);
    chk("t2_sra_rd", 32'(out_rd), 32'd10);
    chk("t2_sra_shin", 32'(out_shift_in), 32'h8000);
    step();

    // Backpressure: A held, B in skid, C refused until space
    out_ready = 1'b0;
    put(1'b1, 16'h6312, 16'hAAAA);
    step();
    put(1'b1, 16'h4401, 16'h5555);
    step();
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_hold_a", 32'({out_mode, out_shift_val, out_rd}), 32'({2'd3, 4'd2, 4'd3}));
    put(1'b1, 16'h0500, 16'h0F0F);
    step();
    chk("t3_still_a", 32'({out_mode, out_shift_val, out_rd, out_shift_in}), 32'({2'd3, 4'd2, 4'd3, 16'hAAAA}));
    chk("t3_c_refused", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("t3_b_out", 32'({out_mode, out_shift_val, out_rd, out_shift_in}), 32'({2'd1, 4'd1, 4'd4, 16'h5555}));
    chk("t3_ready_back", 32'(in_ready), 32'd1);
    step();
    put(1'b0, 16'h0, 16'h0);
    chk("t3_c_out", 32'({out_mode, out_shift_val, out_rd, out_shift_in}), 32'({2'd0, 4'd0, 4'd5, 16'h0F0F}));
    step();
    chk("t3_drained", 32'(out_valid), 32'd0);

    // Flush with both entries full and a third presented
    out_ready = 1'b0;
    put(1'b1, 16'h4111, 16'h0001);
    step();
    put(1'b1, 16'h5222, 16'h0002);
    step();
    put(1'b1, 16'h6333, 16'h0003);
    flush = 1'b1;
    step();
    flush = 1'b0;
    put(1'b0, 16'h0, 16'h0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    put(1'b1, 16'h4444, 16'h0004);
    step();
    put(1'b1, 16'h5555, 16'h0005);
    step();
    put(1'b0, 16'h0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_fields", 32'({out_shift_in, out_shift_val, out_mode, out_rd}), 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    put(1'b1, 16'h4777, 16'h0001);
    step();
    put(1'b0, 16'h0, 16'h0);
    chk("t5_first_after", 32'({out_valid, out_mode, out_shift_val, out_rd, out_shift_in}),
        32'({1'b1, 2'd1, 4'd7, 4'd7, 16'h0001}));
    step();

`ifdef SHIFT_PERF_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    put(1'b1, 16'h6101, 16'h0001);
    step();
    put(1'b1, 16'h6202, 16'h0002);
    step();
    put(1'b1, 16'h0303, 16'h0003);
    step();
    put(1'b0, 16'h0, 16'h0);
    step();
    put(1'b1, 16'h0404, 16'h0004);
    out_ready = 1'b0;
    step();
    put(1'b0, 16'h0, 16'h0);
    repeat (4) step();
    chk("t6_shift_cnt", 32'(perf_shift_cnt), 32'd2);
    chk("t6_stall_cnt", 32'(perf_stall_cnt), 32'd4);
    chk("t6_sat_shift", 32'(s_perf_shift), 32'd2);
    chk("t6_sat_stall", 32'(s_perf_stall), 32'd3);
    out_ready = 1'b1;
    step();
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Registered issue stage directly upstream of the 16-bit Shifter in the EX path.
- Accepts decoded instruction words plus the Rs operand from the decode stage over a valid/ready handshake.
- Extracts the shifter controls Mode and Shift_Val, plus the destination register, and presents them registered to the Shifter.
- Contains a 2-entry skid buffer, so backpressure never drops or duplicates an instruction. Supports a pipeline flush.

Parameters:
DATA_W, 16, operand width; only 16 is supported by the Shifter.
CNT_W, 16, width of the performance counters; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered
in_instr  in  16  instruction [15:12]=opcode [11:8]=rd [7:4]=rs [3:0]=imm
in_rs_data  in  DATA_W  Rs operand value
out_valid  out  1  entry valid toward the Shifter
out_ready  in  1  downstream accepts
out_shift_in  out  DATA_W  to Shift_In
out_shift_val  out  4  to Shift_Val
out_mode  out  2  to Mode: 0=None, 1=SLL, 2=SRA, 3=ROR
out_rd  out  4  destination register tag

Behaviour:
Clock and reset:
- One clock domain; rst_n asserts asynchronously.
- Reset values: out_valid=0, out_shift_in=0, out_shift_val=0, out_mode=0, out_rd=0, in_ready=1, skid entry invalid.
- Reset mid-operation discards both entries; nothing is replayed.

Decode:
- Opcode 4'b0100 gives mode 1; 4'b0101 gives mode 2; 4'b0110 gives mode 3.
- Every other opcode gives mode 0 with shift_val 0, so the Shifter passes the operand through.
- For shift opcodes, shift_val = in_instr[3:0]. A shift_val of 0 is legal and is not rewritten.
- rd = in_instr[11:8] for all opcodes.

Handshake:
- Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Latency: an accepted entry appears on the out_* ports on the next rising edge when the output register is empty or draining.
- Output register loads when it is empty or draining. Its source is the skid entry if that is valid, otherwise the incoming entry.
- Skid entry loads when an entry is accepted while the output register is valid and not draining.
- in_ready(next) = !skid_valid(next). in_ready deasserts only when the skid entry is occupied.
- Order is strictly FIFO and throughput is 1 entry/cycle under no backpressure.
- out_* are held stable while out_valid && !out_ready.
- In_valid without in_ready causes no state change.

Flush:
- Clears out_valid and skid_valid at the edge; in_ready=1 on the next cycle.
- An entry presented in the same cycle as flush is dropped.
- Flush dominates simultaneous transfer in and transfer out; the downstream transfer still counts as completed.

Optional Feature:
Macro SHIFT_PERF_CNT_EN.
- When defined, adds ports perf_shift_cnt (out, CNT_W) and perf_stall_cnt (out, CNT_W). Both reset to 0 and saturate at all-ones.
- perf_shift_cnt increments on each output transfer with out_mode != 0.
- perf_stall_cnt increments each cycle with out_valid && !out_ready.
- Flush does not clear the counters.
- When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package wisc_pkg holds:
  - opcode constants OP_SLL=4'b0100, OP_SRA=4'b0101, OP_ROR=4'b0110;
  - shift mode constants MODE_NONE, MODE_SLL, MODE_SRA, MODE_ROR;
  - an issue-entry struct {shift_in, shift_val, mode, rd}.
- One combinational sub-module, shift_decode: instr in, {mode, shift_val, rd} out. The stage instantiates it once on the input path.

Test Plan:
1. Reset release, then in_instr=16'h4123, in_rs_data=16'h00F0, out_ready=1 -> next cycle out_valid=1, out_mode=1, out_shift_val=3, out_rd=1, out_shift_in=16'h00F0.
2. ADD 16'h0215, rs=16'h1234 -> out_mode=0, out_shift_val=0, out_rd=2, out_shift_in=16'h1234. SRA 16'h5A3F, rs=16'h8000 -> out_mode=2, out_shift_val=15, out_rd=10.
3. Backpressure: out_ready=0 while feeding 3 back-to-back entries A,B,C -> A held on outputs, B in skid, in_ready=0, C not accepted. Release out_ready -> A,B,C emerge in order with no duplicates.
4. Flush with both entries full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appears at the output.
5. rst_n pulsed low asynchronously mid-stall -> outputs return to reset values immediately. The entry presented after reset is the first one observed at the output.
6. With SHIFT_PERF_CNT_EN: issue 2 ROR and 1 ADD, then stall 4 cycles -> perf_shift_cnt=2, perf_stall_cnt=4. Preload near saturation -> counters stick at 16'hFFFF.
